// File: rtl/morse_sequencer_if.sv
// Start/Done handshake and key output between the lookup/controller and the Morse keyer.
// i_Abort exists only when MORSE_SEQ_ABORT_EN is defined.
interface morse_sequencer_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
);
    logic               i_Start;
    logic [MAX_LEN-1:0] i_Morse_Pattern;
    logic [LEN_W-1:0]   i_Morse_Length;
`ifdef MORSE_SEQ_ABORT_EN
    logic               i_Abort;
`endif
    logic               o_LED;
    logic               o_Busy;
    logic               o_Done;

    modport master (
`ifdef MORSE_SEQ_ABORT_EN
        output i_Abort,
`endif
        output i_Start, i_Morse_Pattern, i_Morse_Length,
        input  o_LED, o_Busy, o_Done
    );

    modport slave (
`ifdef MORSE_SEQ_ABORT_EN
        input  i_Abort,
`endif
        input  i_Start, i_Morse_Pattern, i_Morse_Length,
        output o_LED, o_Busy, o_Done
    );
endinterface

// File: rtl/morse_sequencer.sv
// Morse keyer: plays a latched MSB-first dot/dash pattern on o_LED with unit-based timing.
// Optional MORSE_SEQ_ABORT_EN adds an abort input that returns the keyer to IDLE.
//
// state | meaning
// IDLE  | waiting for i_Start with a non-zero length
// ON    | LED lit for the current symbol (dot or dash)
// OFF   | inter-symbol gap
// TAIL  | character gap after the last symbol
// DONE  | o_Done high until i_Start is seen low
module morse_sequencer #(
    parameter int UNIT_CYCLES    = 6250000,
    parameter int MAX_LEN        = 8,
    parameter int LEN_W          = 4,
    parameter int DASH_UNITS     = 3,
    parameter int GAP_UNITS      = 1,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int CNT_W          = 25
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    morse_sequencer_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_TAIL = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAIL_LD = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               abort;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] pat_shift;

`ifdef MORSE_SEQ_ABORT_EN
    assign abort = bus.i_Abort;
`else
    assign abort = 1'b0;
`endif

    assign len_clamped = (bus.i_Morse_Length > LEN_MAX) ? LEN_MAX : bus.i_Morse_Length;
    // The current symbol is always the MSB of pat_q; it shifts left as each symbol completes.
    assign pat_shift   = pat_q << 1;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pat_d   = pat_q;
        case (state_q)
            S_IDLE: begin
                if (!abort && bus.i_Start && (bus.i_Morse_Length != '0)) begin
                    state_d = S_ON;
                    pat_d   = bus.i_Morse_Pattern;
                    len_d   = len_clamped;
                    idx_d   = '0;
                    cnt_d   = bus.i_Morse_Pattern[MAX_LEN-1] ? DASH_LD : DOT_LD;
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = S_TAIL;
                        cnt_d   = TAIL_LD;
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = GAP_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OFF: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                    idx_d   = idx_q + LEN_W'(1);
                    pat_d   = pat_shift;
                    cnt_d   = pat_shift[MAX_LEN-1] ? DASH_LD : DOT_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_TAIL: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!bus.i_Start) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        // Abort overrides every transition once a character has been accepted.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    always_comb begin
        led_d  = (state_d == S_ON);
        busy_d = (state_d == S_ON) || (state_d == S_OFF) || (state_d == S_TAIL);
        done_d = (state_d == S_DONE);
    end

    assign bus.o_LED  = led_q;
    assign bus.o_Busy = busy_q;
    assign bus.o_Done = done_q;
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with UNIT_CYCLES=4 (dot 4, dash 12, gap 4, tail 12 cycles).
module tb_morse_sequencer;
    localparam int LIMIT = 200;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    morse_sequencer_if #(.MAX_LEN(8), .LEN_W(4)) bus ();

    morse_sequencer #(.UNIT_CYCLES(4), .MAX_LEN(8), .LEN_W(4), .DASH_UNITS(3),
                      .GAP_UNITS(1), .CHAR_GAP_UNITS(3), .CNT_W(25))
        dut (.i_Clock(clk), .i_Reset_n(rst_n), .bus(bus));

    // Counts consecutive negedge samples with LED at 'level' while busy; stops on the first other sample.
    task automatic measure(input logic level, output int n);
        n = 0;
        while (bus.o_LED === level && bus.o_Busy === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_state: got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
    endtask

    task automatic test_letter_a();
        int n;
        int exp_len [4] = '{4, 4, 12, 12};
        bus.i_Morse_Pattern = 8'b0100_0000;
        bus.i_Morse_Length  = 4'd2;
        bus.i_Start         = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            measure((s % 2 == 0) ? 1'b1 : 1'b0, n);
            vectors++;
            if (n !== exp_len[s]) begin
                errors++;
                $display("FAIL a_segment%0d: got %0d cycles expected %0d", s, n, exp_len[s]);
            end
        end
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b001) begin
            errors++;
            $display("FAIL a_done_edge: got %b expected 001", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        @(negedge clk);
        vectors++;
        if (bus.o_Done !== 1'b1) begin
            errors++;
            $display("FAIL a_done_hold: got %b expected 1", bus.o_Done);
        end
        bus.i_Start = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_Done !== 1'b0) begin
            errors++;
            $display("FAIL a_done_drop: got %b expected 0", bus.o_Done);
        end
    endtask

    task automatic test_zero_length();
        bus.i_Morse_Pattern = 8'hFF;
        bus.i_Morse_Length  = 4'd0;
        bus.i_Start         = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
                errors++;
                $display("FAIL zero_len_c%0d: got %b expected 000", c, {bus.o_LED, bus.o_Busy, bus.o_Done});
            end
        end
        bus.i_Start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_length();
        int n;
        logic [3:0] lens [2] = '{4'd8, 4'd15};
        for (int r = 0; r < 2; r++) begin
            bus.i_Morse_Pattern = 8'hFF;
            bus.i_Morse_Length  = lens[r];
            bus.i_Start         = 1'b1;
            @(negedge clk);
            for (int s = 0; s < 8; s++) begin
                measure(1'b1, n);
                if (s == 0) bus.i_Morse_Pattern = 8'h00;
                vectors++;
                if (n !== 12) begin
                    errors++;
                    $display("FAIL len%0d_dash%0d: got %0d cycles expected 12", lens[r], s, n);
                end
                if (s < 7) begin
                    measure(1'b0, n);
                    vectors++;
                    if (n !== 4) begin
                        errors++;
                        $display("FAIL len%0d_gap%0d: got %0d cycles expected 4", lens[r], s, n);
                    end
                end
            end
            measure(1'b0, n);
            vectors++;
            if (n !== 12) begin
                errors++;
                $display("FAIL len%0d_tail: got %0d cycles expected 12", lens[r], n);
            end
            vectors++;
            if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b001) begin
                errors++;
                $display("FAIL len%0d_done: got %b expected 001", lens[r], {bus.o_LED, bus.o_Busy, bus.o_Done});
            end
            bus.i_Start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bus.i_Morse_Pattern = 8'b0000_0000;
        bus.i_Morse_Length  = 4'd1;
        bus.i_Start         = 1'b1;
        @(negedge clk);
        measure(1'b1, n);
        measure(1'b0, n);
        for (int c = 0; c < 50; c++) begin
            vectors++;
            if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b001) begin
                errors++;
                $display("FAIL hold_done_c%0d: got %b expected 001", c, {bus.o_LED, bus.o_Busy, bus.o_Done});
            end
            @(negedge clk);
        end
        bus.i_Start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_idle: got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        bus.i_Start = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_restart: got %b expected 110", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        measure(1'b1, n);
        vectors++;
        if (n !== 4) begin
            errors++;
            $display("FAIL b2b_dot: got %0d cycles expected 4", n);
        end
        measure(1'b0, n);
        vectors++;
        if (n !== 12) begin
            errors++;
            $display("FAIL b2b_tail: got %0d cycles expected 12", n);
        end
        bus.i_Start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n;
        bus.i_Morse_Pattern = 8'b0100_0000;
        bus.i_Morse_Length  = 4'd2;
        bus.i_Start         = 1'b1;
        @(negedge clk);
        measure(1'b1, n);
        measure(1'b0, n);
        bus.i_Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle_c%0d: got %b expected 000", c, {bus.o_LED, bus.o_Busy, bus.o_Done});
            end
        end
        bus.i_Start = 1'b1;
        @(negedge clk);
        measure(1'b1, n);
        vectors++;
        if (n !== 4) begin
            errors++;
            $display("FAIL post_reset_dot: got %0d cycles expected 4", n);
        end
        measure(1'b0, n);
        measure(1'b1, n);
        measure(1'b0, n);
        bus.i_Start = 1'b0;
        @(negedge clk);
    endtask

`ifdef MORSE_SEQ_ABORT_EN
    task automatic test_abort();
        int n;
        bus.i_Morse_Pattern = 8'b0100_0000;
        bus.i_Morse_Length  = 4'd2;
        bus.i_Start         = 1'b1;
        @(negedge clk);
        measure(1'b1, n);
        bus.i_Abort = 1'b1;
        bus.i_Start = 1'b0;
        @(negedge clk);
        bus.i_Abort = 1'b0;
        vectors++;
        if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_off: got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
        end
        bus.i_Abort = 1'b1;
        bus.i_Start = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_block: got %b expected 0", bus.o_Busy);
        end
        bus.i_Abort = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.o_Busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_release_accept: got %b expected 1", bus.o_Busy);
        end
        bus.i_Abort = 1'b1;
        bus.i_Start = 1'b0;
        @(negedge clk);
        bus.i_Abort = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        bus.i_Start         = 1'b0;
        bus.i_Morse_Pattern = '0;
        bus.i_Morse_Length  = '0;
`ifdef MORSE_SEQ_ABORT_EN
        bus.i_Abort         = 1'b0;
`endif
        test_reset();
        test_letter_a();
        test_zero_length();
        test_full_length();
        test_back_to_back();
        test_async_reset();
`ifdef MORSE_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
